// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: PC stage, instruction-memory and decode handshakes.
interface if_fetch_queue_if;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    // Queue side
    modport slave (
        input  pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o,
               instr_o, instr_pc_o
    );

    // Environment side (PC stage, memory, decode)
    modport master (
        output pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o,
               instr_o, instr_pc_o
    );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue with credit-limited requests and
// flush-time discard of in-flight memory responses.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    if_fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    pc_d   [DEPTH];
    logic [31:0]    word_q [DEPTH];
    logic [31:0]    word_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [PW-1:0]  alloc_q, alloc_d;
    logic [PW-1:0]  fill_q,  fill_d;
    logic [PW-1:0]  rd_q,    rd_d;
    logic [CW-1:0]  occ_q,   occ_d;
    logic [CW-1:0]  drop_q,  drop_d;
    // Allocated entries still waiting for their response
    logic [CW-1:0]  pend_q,  pend_d;

    logic           req_c;
    logic           grant_c;
    logic           fill_c;
    logic           drop_rsp_c;
    logic           valid_c;
    logic           pop_c;
    logic [CW-1:0]  inflight_c;

    // Handshake decode, pointer/counter next state and entry updates
    always_comb begin
        pc_d       = pc_q;
        word_d     = word_q;
        filled_d   = filled_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        pend_d     = pend_q;

        req_c      = rstn_i & bus.pc_valid_i & ~bus.flush_i
                     & (occ_q < CW'(DEPTH)) & (drop_q == '0);
        grant_c    = req_c & bus.imem_gnt_i;
        drop_rsp_c = bus.imem_rvalid_i & (drop_q != '0);
        fill_c     = bus.imem_rvalid_i & (drop_q == '0) & (pend_q != '0);
        valid_c    = (occ_q != '0) & filled_q[rd_q];
        pop_c      = valid_c & bus.instr_ready_i & ~bus.flush_i;
        inflight_c = pend_q + drop_q;

        if (bus.flush_i) begin
            alloc_d  = '0;
            fill_d   = '0;
            rd_d     = '0;
            occ_d    = '0;
            pend_d   = '0;
            filled_d = '0;
            // A response arriving in the flush cycle retires one in-flight slot
            if (bus.imem_rvalid_i && (inflight_c != '0)) begin
                drop_d = inflight_c - CW'(1);
            end else begin
                drop_d = inflight_c;
            end
        end else begin
            if (grant_c) begin
                pc_d[alloc_q]     = bus.pc_i;
                filled_d[alloc_q] = 1'b0;
                alloc_d           = alloc_q + PW'(1);
            end
            if (drop_rsp_c) begin
                drop_d = drop_q - CW'(1);
            end
            if (fill_c) begin
                word_d[fill_q]   = bus.imem_rdata_i;
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PW'(1);
            end
            if (pop_c) begin
                filled_d[rd_q] = 1'b0;
                rd_d           = rd_q + PW'(1);
            end
            occ_d  = occ_q + CW'(grant_c) - CW'(pop_c);
            pend_d = pend_q + CW'(grant_c) - CW'(fill_c);
        end
    end

    // State registers; reset also clears entry contents
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
            filled_q <= '0;
            alloc_q  <= '0;
            fill_q   <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
            pend_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            word_q   <= word_d;
            filled_q <= filled_d;
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.imem_req_o    = req_c;
    assign bus.pc_ready_o    = grant_c;
    assign bus.imem_addr_o   = {bus.pc_i[31:2], 2'b00};
    assign bus.instr_valid_o = valid_c;
    assign bus.instr_o       = word_q[rd_q];
    assign bus.instr_pc_o    = pc_q[rd_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4).
module tb_if_fetch_queue;
    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    if_fetch_queue_if bus ();

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        bus.pc_i          = 32'h1234_5677;
        bus.pc_valid_i    = 1'b1;
        bus.flush_i       = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;

        // Reset held with a pending PC
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      32'(bus.imem_req_o), 32'd0);
        chk("rst_pc_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("rst_valid",    32'(bus.instr_valid_o), 32'd0);
        chk("rst_addr",     bus.imem_addr_o, 32'h1234_5674);
        chk("rst_instr",    bus.instr_o, 32'd0);
        chk("rst_instr_pc", bus.instr_pc_o, 32'd0);

        // Release: request immediately
        rstn = 1'b1;
        #1;
        chk("rel_req",      32'(bus.imem_req_o), 32'd1);
        chk("rel_pc_ready", 32'(bus.pc_ready_o), 32'd1);
        tick();
        bus.pc_valid_i = 1'b0;
        #1;
        chk("rel_gnt_valid", 32'(bus.instr_valid_o), 32'd0);

        // Reset mid-operation clears entries; late response is spurious
        rstn = 1'b0;
        #1;
        chk("midrst_pc", bus.instr_pc_o, 32'd0);
        tick();
        rstn = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("midrst_spur_valid", 32'(bus.instr_valid_o), 32'd0);

        // Streaming, k=1, ready=1
        for (int i = 0; i < 6; i++) begin
            bus.pc_valid_i    = (i < 4);
            bus.pc_i          = 32'(4 * i);
            bus.instr_ready_i = 1'b1;
            bus.imem_rvalid_i = (i >= 1) && (i <= 4);
            bus.imem_rdata_i  = 32'hA000_0000 + 32'(i - 1);
            #1;
            if (i < 4) chk("str_pc_ready", 32'(bus.pc_ready_o), 32'd1);
            chk("str_valid", 32'(bus.instr_valid_o), 32'(i >= 2));
            if (i >= 2) begin
                chk("str_instr_pc", bus.instr_pc_o, 32'(4 * (i - 2)));
                chk("str_instr",    bus.instr_o, 32'hA000_0000 + 32'(i - 2));
            end
            tick();
        end
        bus.imem_rvalid_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        #1;
        chk("str_drained", 32'(bus.instr_valid_o), 32'd0);

        // Backpressure: fill all four entries
        for (int i = 0; i < 4; i++) begin
            bus.pc_valid_i    = 1'b1;
            bus.pc_i          = 32'h20 + 32'(4 * i);
            bus.imem_rvalid_i = (i >= 1);
            bus.imem_rdata_i  = 32'hB000_0000 + 32'(i - 1);
            #1;
            chk("bp_pc_ready", 32'(bus.pc_ready_o), 32'd1);
            tick();
        end
        bus.pc_i          = 32'h30;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hB000_0003;
        #1;
        chk("bp_full_req", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.imem_rvalid_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("bp_head_pc",   bus.instr_pc_o, 32'h20);
        chk("bp_head_word", bus.instr_o, 32'hB000_0000);
        chk("bp_pop_req",   32'(bus.imem_req_o), 32'd0);
        tick();
        bus.instr_ready_i = 1'b0;
        #1;
        chk("bp_regrant", 32'(bus.pc_ready_o), 32'd1);
        tick();
        #1;
        chk("bp_full_again", 32'(bus.imem_req_o), 32'd0);
        bus.pc_valid_i = 1'b0;

        // Full queue: pop and fill in one cycle, then a spurious response
        bus.instr_ready_i = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hC0DE_0030;
        #1;
        chk("sc_head_pc", bus.instr_pc_o, 32'h24);
        chk("sc_head_w",  bus.instr_o, 32'hB000_0001);
        tick();
        bus.imem_rdata_i = 32'h0BAD_0BAD;
        #1;
        chk("sc_h2_pc", bus.instr_pc_o, 32'h28);
        chk("sc_h2_w",  bus.instr_o, 32'hB000_0002);
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("sc_h3_pc", bus.instr_pc_o, 32'h2C);
        chk("sc_h3_w",  bus.instr_o, 32'hB000_0003);
        tick();
        #1;
        chk("sc_h4_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("sc_h4_pc",    bus.instr_pc_o, 32'h30);
        chk("sc_h4_w",     bus.instr_o, 32'hC0DE_0030);
        tick();
        bus.instr_ready_i = 1'b0;
        #1;
        chk("sc_empty", 32'(bus.instr_valid_o), 32'd0);

        // New entry after spurious response must wait for its own data
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h40;
        tick();
        bus.pc_valid_i = 1'b0;
        #1;
        chk("sp_unfilled", 32'(bus.instr_valid_o), 32'd0);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hD000_0040;
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("sp_fill_w", bus.instr_o, 32'hD000_0040);
        bus.instr_ready_i = 1'b1;
        tick();
        bus.instr_ready_i = 1'b0;

        // Grant stall: three cycles without gnt
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h50;
        bus.imem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req",      32'(bus.imem_req_o), 32'd1);
            chk("stall_pc_ready", 32'(bus.pc_ready_o), 32'd0);
            tick();
        end
        bus.imem_gnt_i = 1'b1;
        #1;
        chk("stall_go", 32'(bus.pc_ready_o), 32'd1);
        tick();
        bus.pc_valid_i    = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hD000_0050;
        tick();
        bus.imem_rvalid_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("stall_pc", bus.instr_pc_o, 32'h50);
        tick();
        bus.instr_ready_i = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("stall_single", 32'(bus.instr_valid_o), 32'd0);

        // Flush with two requests in flight, k=3
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h60;
        tick();
        bus.pc_i = 32'h64;
        tick();
        bus.pc_valid_i = 1'b0;
        bus.flush_i    = 1'b1;
        #1;
        chk("fl_req_flush", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.flush_i       = 1'b0;
        bus.pc_valid_i    = 1'b1;
        bus.pc_i          = 32'h100;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_0060;
        #1;
        chk("fl_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("fl_req_d2", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.imem_rdata_i = 32'hBAD0_0064;
        #1;
        chk("fl_req_d1", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("fl_resume", 32'(bus.pc_ready_o), 32'd1);
        tick();
        bus.pc_valid_i    = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hE000_0100;
        #1;
        chk("fl_not_yet", 32'(bus.instr_valid_o), 32'd0);
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("fl_new_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("fl_new_pc",    bus.instr_pc_o, 32'h100);
        chk("fl_new_w",     bus.instr_o, 32'hE000_0100);
        bus.instr_ready_i = 1'b1;
        tick();
        bus.instr_ready_i = 1'b0;

        // Back-to-back flushes, first one coincides with a response
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h200;
        tick();
        bus.pc_i = 32'h204;
        tick();
        bus.pc_valid_i    = 1'b0;
        bus.flush_i       = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        tick();
        bus.imem_rvalid_i = 1'b0;
        tick();
        bus.flush_i       = 1'b0;
        bus.pc_valid_i    = 1'b1;
        bus.pc_i          = 32'h300;
        bus.imem_rvalid_i = 1'b1;
        #1;
        chk("bb_req_blocked", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("bb_resume", 32'(bus.imem_req_o), 32'd1);
        bus.pc_valid_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
